i2s_stereo_rx: RTL and testbench

I2S_STEREO_RX -- requirements
Module: i2s_stereo_rx

---
 rtl/common_pkg.sv | 7 +
 rtl/i2s_in_sync.sv | 48 ++++
 rtl/i2s_stereo_rx.sv | 125 ++++++++++++
 tb/tb_i2s_stereo_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared constants for the audio front-end: I2S word width and the accepted
// range of slot lengths, in bit clocks.
package common;
  localparam int I2S_BITS     = 32;
  localparam int I2S_MIN_SLOT = 16;
  localparam int I2S_MAX_SLOT = 64;
endpackage

// File: rtl/i2s_in_sync.sv
// Two-flop synchronizer for one asynchronous input, with an optional
// registered rising-edge pulse on the synchronized value.
module i2s_in_sync #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);
  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;
      logic rise_q;
      // The pulse lands one clk after the synchronized input goes 0->1.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          prev_q <= 1'b0;
          rise_q <= 1'b0;
        end else begin
          prev_q <= sync_q;
          rise_q <= sync_q & ~prev_q;
        end
      end
      assign rise_o = rise_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/i2s_stereo_rx.sv
// I2S stereo receiver: frames slots on lrck boundaries, checks slot length,
// locks after a clean L+R pair and presents {left, right} with a start pulse.
module i2s_stereo_rx
  import common::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i2s_bck,
  input  logic                  i2s_lrck,
  input  logic                  i2s_sd,
  output logic [I2S_BITS*2-1:0] data,
  output logic                  start,
  output logic                  locked,
  output logic                  frame_err
);
  localparam int CW = $clog2(I2S_MAX_SLOT + 2);
  localparam logic [CW-1:0] CNT_SAT  = CW'(I2S_MAX_SLOT + 1);
  localparam logic [CW-1:0] LEN_MIN  = CW'(I2S_MIN_SLOT);
  localparam logic [CW-1:0] LEN_MAX  = CW'(I2S_MAX_SLOT);

  typedef enum logic [1:0] {IDLE, SYNC, LEFT_OK, RUN} state_t;

  logic bck_rise;
  logic bck_s_unused;
  logic lrck_s;
  logic lrck_rise_unused;
  logic sd_s;
  logic sd_rise_unused;

  i2s_in_sync #(.EDGE_EN(1'b1)) u_sync_bck (
    .clk(clk), .resetn(resetn), .d_i(i2s_bck), .q_o(bck_s_unused), .rise_o(bck_rise)
  );
  i2s_in_sync #(.EDGE_EN(1'b0)) u_sync_lrck (
    .clk(clk), .resetn(resetn), .d_i(i2s_lrck), .q_o(lrck_s), .rise_o(lrck_rise_unused)
  );
  i2s_in_sync #(.EDGE_EN(1'b0)) u_sync_sd (
    .clk(clk), .resetn(resetn), .d_i(i2s_sd), .q_o(sd_s), .rise_o(sd_rise_unused)
  );

  state_t                  state_q;
  logic [I2S_BITS-1:0]     sh_q, sh_d;
  logic [I2S_BITS-1:0]     left_hold_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    lrck_prev_q;
  logic [I2S_BITS*2-1:0]   data_q;
  logic                    start_q;
  logic                    locked_q;
  logic                    frame_err_q;

  logic                    boundary;
  logic [CW-1:0]           slot_len;
  logic                    slot_ok;
  logic                    timeout;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sh_d = sh_q;
    for (int i = 0; i < I2S_BITS; i++) begin
      if (CW'(I2S_BITS - 1 - i) == cnt_q) sh_d[i] = sd_s;
    end
    cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    boundary = (lrck_s != lrck_prev_q);
    slot_len = cnt_q + 1'b1;
    slot_ok  = (slot_len >= LEN_MIN) && (slot_len <= LEN_MAX);
    timeout  = !boundary && (cnt_q == LEN_MAX);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      left_hold_q <= '0;
      cnt_q       <= '0;
      lrck_prev_q <= 1'b0;
      data_q      <= '0;
      start_q     <= 1'b0;
      locked_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      start_q     <= 1'b0;
      frame_err_q <= 1'b0;
      if (bck_rise) begin
        if (boundary) begin
          sh_q        <= '0;
          cnt_q       <= '0;
          lrck_prev_q <= lrck_s;
        end else begin
          sh_q  <= sh_d;
          cnt_q <= cnt_d;
        end

        if (state_q == IDLE) begin
          // The partial slot seen before the first boundary is never trusted.
          if (boundary) state_q <= SYNC;
        end else if ((boundary && !slot_ok) || timeout) begin
          frame_err_q <= 1'b1;
          locked_q    <= 1'b0;
          state_q     <= SYNC;
        end else if (boundary) begin
          // lrck_prev_q names the slot being closed: 0 = left, 1 = right.
          case (state_q)
            SYNC:    if (!lrck_prev_q) state_q <= LEFT_OK;
            LEFT_OK: if (lrck_prev_q) begin
                       state_q  <= RUN;
                       locked_q <= 1'b1;
                     end
            RUN:     if (!lrck_prev_q) begin
                       left_hold_q <= sh_d;
                     end else begin
                       data_q  <= {left_hold_q, sh_d};
                       start_q <= 1'b1;
                     end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign data      = data_q;
  assign start     = start_q;
  assign locked    = locked_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_i2s_stereo_rx.sv
// Scoreboard bench for i2s_stereo_rx: slot-level reference model feeds an
// expected-event queue, a monitor pops it on every start / frame_err.
module tb_i2s_stereo_rx;
  import common::*;
  localparam int W = I2S_BITS;

  logic           clk = 1'b0;
  logic           resetn;
  logic           i2s_bck, i2s_lrck, i2s_sd;
  logic [2*W-1:0] data;
  logic           start, locked, frame_err;

  always #5 clk = ~clk;

  i2s_stereo_rx dut (
    .clk(clk), .resetn(resetn), .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck), .i2s_sd(i2s_sd),
    .data(data), .start(start), .locked(locked), .frame_err(frame_err)
  );

  typedef struct { bit ch; int len; logic [W-1:0] val; int half; } slot_t;
  typedef struct { bit is_err; logic [2*W-1:0] data; bit lock; } ev_t;

  slot_t          slots[$];
  ev_t            exp_q[$];
  logic [2*W-1:0] seen_q[$];
  int             n_checks = 0;
  int             n_fail = 0;
  int             n_start_seen = 0;
  int             n_start_exp = 0;

  // Reference model state: -1 before first boundary, 0 hunting, 1 left seen, 2 locked
  int             m_stage;
  logic [W-1:0]   m_hold;
  logic [2*W-1:0] m_data;
  bit             m_locked;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] msb_align(input logic [W-1:0] v, input int len);
    logic [W-1:0] m;
    if (len >= W) return v;
    m = '1;
    m = m << (W - len);
    return v & m;
  endfunction

  function automatic slot_t mk(input bit ch, input int len, input logic [W-1:0] val, input int half);
    slot_t s;
    s.ch = ch; s.len = len; s.val = val; s.half = half;
    return s;
  endfunction

  task automatic model_reset();
    m_stage = -1; m_hold = '0; m_data = '0; m_locked = 1'b0;
  endtask

  task automatic model_close(input slot_t s);
    bit ok;
    ok = (s.len >= I2S_MIN_SLOT) && (s.len <= I2S_MAX_SLOT);
    if (m_stage < 0) begin
      m_stage = 0;
      return;
    end
    if (!ok) begin
      // A slot longer than MAX+1 first times out, then closes too long.
      exp_q.push_back('{1'b1, m_data, 1'b0});
      if (s.len > I2S_MAX_SLOT + 1) exp_q.push_back('{1'b1, m_data, 1'b0});
      m_stage = 0; m_locked = 1'b0;
      return;
    end
    case (m_stage)
      0: if (!s.ch) m_stage = 1;
      1: if (s.ch) begin m_stage = 2; m_locked = 1'b1; end
      default: begin
        if (!s.ch) m_hold = msb_align(s.val, s.len);
        else begin
          m_data = {m_hold, msb_align(s.val, s.len)};
          exp_q.push_back('{1'b0, m_data, 1'b1});
          n_start_exp++;
        end
      end
    endcase
  endtask

  task automatic bck_period(input bit lr, input bit sd, input int half);
    i2s_bck = 1'b0; i2s_lrck = lr; i2s_sd = sd;
    repeat (half) @(negedge clk);
    i2s_bck = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  // Serialise the slot list with the standard one-bck data delay; slots whose
  // closing period is driven are fed to the model before any stimulus.
  task automatic run_stream(input int max_periods);
    bit lr_q[$]; bit bit_q[$]; int half_q[$]; int starts[$];
    int total;
    logic [W-1:0] v;
    foreach (slots[k]) begin
      starts.push_back(lr_q.size());
      for (int i = 0; i < slots[k].len; i++) begin
        lr_q.push_back(slots[k].ch);
        half_q.push_back(slots[k].half);
        v = slots[k].val << i;
        bit_q.push_back((i < W) ? v[W-1] : 1'($urandom_range(0, 1)));
      end
    end
    total = (lr_q.size() < max_periods) ? lr_q.size() : max_periods;
    for (int k = 0; k + 1 < slots.size(); k++)
      if (starts[k+1] < total) model_close(slots[k]);
    for (int p = 0; p < total; p++)
      bck_period(lr_q[p], (p == 0) ? 1'b0 : bit_q[p-1], half_q[p]);
  endtask

  task automatic add_frame(input int ll, input logic [W-1:0] lv, input int rl, input logic [W-1:0] rv, input int half);
    slots.push_back(mk(1'b0, ll, lv, half));
    slots.push_back(mk(1'b1, rl, rv, half));
  endtask

  function automatic int rand_len();
    if ($urandom_range(0, 9) != 0) return int'($urandom_range(16, 64));
    if ($urandom_range(0, 1) != 0) return int'($urandom_range(8, 15));
    return int'($urandom_range(65, 70));
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"}, data, '0);
    check({tag, "_start"}, {63'd0, start}, '0);
    check({tag, "_locked"}, {63'd0, locked}, '0);
    check({tag, "_frame_err"}, {63'd0, frame_err}, '0);
  endtask

  // Monitor: every start or frame_err must match the head of the queue.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && (start === 1'b1 || frame_err === 1'b1)) begin
        check("start_and_err_exclusive", {63'd0, start & frame_err}, '0);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_event: start=%b frame_err=%b data=%h, expected none", start, frame_err, data);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", {63'd0, frame_err}, {63'd0, e.is_err});
          check("event_data", data, e.data);
          check("event_locked", {63'd0, locked}, {63'd0, e.lock});
        end
        if (start === 1'b1) begin
          n_start_seen++;
          seen_q.push_back(data);
        end
      end
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; i2s_bck = 1'b0; i2s_lrck = 1'b0; i2s_sd = 1'b0;
    #2;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Run 1: directed patterns then randomised slot lengths
    model_reset();
    slots.delete();
    repeat (4) add_frame(32, 32'hA5A5_1234, 32, 32'h0F0F_8001, 4);
    repeat (3) add_frame(16, 32'h8001_0000, 16, 32'h7FFE_0000, 4);
    add_frame(24, $urandom, 32, $urandom, 4);
    add_frame(8, $urandom, 32, $urandom, 4);
    repeat (2) add_frame(32, $urandom, 32, $urandom, 4);
    add_frame(80, $urandom, 32, $urandom, 4);
    repeat (3) add_frame(32, $urandom, 32, $urandom, 4);
    for (int f = 0; f < 110; f++) add_frame(rand_len(), $urandom, rand_len(), $urandom, 2);
    slots.push_back(mk(1'b0, 16, '0, 2));
    run_stream(1 << 30);
    repeat (40) @(negedge clk);
    check("run1_drain", 64'(exp_q.size()), '0);
    check("run1_locked_end", {63'd0, locked}, {63'd0, m_locked});
    check("first_start_data", (seen_q.size() > 0) ? seen_q[0] : '0, 64'hA5A5_1234_0F0F_8001);
    check("start16_data", (seen_q.size() > 2) ? seen_q[2] : '0, 64'h8001_0000_7FFE_0000);

    // Run 2: lock up, then reset in the middle of a right slot
    resetn = 1'b0; i2s_bck = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    model_reset();
    slots.delete();
    repeat (4) add_frame(32, $urandom, 32, $urandom, 4);
    slots.push_back(mk(1'b0, 32, $urandom, 4));
    slots.push_back(mk(1'b1, 32, $urandom, 4));
    run_stream(9 * 32 + 12);
    repeat (20) @(negedge clk);
    check("run2_drain", 64'(exp_q.size()), '0);
    check("run2_locked_before_reset", {63'd0, locked}, 64'd1);
    #3;
    resetn = 1'b0;
    #1;
    check_outputs_zero("midslot_reset");
    i2s_bck = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;

    // Run 3: fresh stream after release must fully resync before any start
    model_reset();
    slots.delete();
    for (int f = 0; f < 4; f++)
      add_frame(int'($urandom_range(16, 64)), $urandom, int'($urandom_range(16, 64)), $urandom, 4);
    slots.push_back(mk(1'b0, 16, '0, 4));
    run_stream(1 << 30);
    repeat (40) @(negedge clk);
    check("run3_drain", 64'(exp_q.size()), '0);
    check("run3_locked_end", {63'd0, locked}, {63'd0, m_locked});
    check("start_count", 64'(n_start_seen), 64'(n_start_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
